// File: rtl/ssd_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ssd_if_pkg
// Brief    : Shared opcodes, block size, engine states and command record for
//            the SSD command responder.
// Revision : 1.0 - initial release
// ============================================================================
package ssd_if_pkg;

    localparam logic [7:0] OP_READ    = 8'd0;
    localparam logic [7:0] OP_WRITE   = 8'd1;
    localparam int         BLOCK_SIZE = 4096;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [63:0] lba;
        logic [31:0] length;
        logic [63:0] data;
    } ssd_cmd_t;

endpackage
`default_nettype wire

// File: rtl/ssd_cmd_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : ssd_cmd_responder_if
// Brief    : SSD command/response bus between an initiator and the responder.
// Revision : 1.0 - initial release
// ============================================================================
interface ssd_cmd_responder_if;

    logic        ssd_cmd_valid;
    logic        ssd_cmd_ready;
    logic [7:0]  ssd_opcode;
    logic [63:0] ssd_lba;
    logic [31:0] ssd_length;
    logic [63:0] ssd_data;
    logic        ssd_data_ready;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic [63:0] rsp_lba;

    modport master (
        output ssd_cmd_valid, ssd_opcode, ssd_lba, ssd_length, ssd_data,
        input  ssd_cmd_ready, ssd_data_ready, rsp_data, rsp_err, rsp_lba
    );

    modport slave (
        input  ssd_cmd_valid, ssd_opcode, ssd_lba, ssd_length, ssd_data,
        output ssd_cmd_ready, ssd_data_ready, rsp_data, rsp_err, rsp_lba
    );

endinterface
`default_nettype wire

// File: rtl/ssd_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ssd_cmd_fifo
// Brief    : In-order command queue; push is ignored when full, pop when empty.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_cmd_fifo
    import ssd_if_pkg::*;
#(
    parameter int  QDEPTH = 4,
    parameter type T      = ssd_cmd_t
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      push,
    input  wire T                          din,
    input  wire logic                      pop,
    output T                               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(QDEPTH):0]        count
);

    localparam int c_PTR_W = $clog2(QDEPTH);

    T                   r_mem [QDEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == (c_PTR_W+1)'(QDEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ssd_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : ssd_cmd_responder
// Brief    : SSD target model: queued block commands, per-opcode service
//            latency, block-indexed backing store, one-cycle completion pulse.
//            Define SSD_RESP_STATS_EN to add saturating statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
module ssd_cmd_responder #(
    parameter int QDEPTH     = 4,
    parameter int ADDR_W     = 6,
    parameter int RD_LAT     = 3,
    parameter int WR_LAT     = 5,
    parameter int ERR_LAT    = 1,
    parameter int BLOCK_SIZE = 4096
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ssd_cmd_responder_if.slave bus,
    output logic               busy
`ifdef SSD_RESP_STATS_EN
    ,
    output logic [31:0]        stat_reads,
    output logic [31:0]        stat_writes,
    output logic [31:0]        stat_errors,
    output logic [31:0]        stat_busy_cycles
`endif
);

    import ssd_if_pkg::*;

    localparam int c_OFS_W   = $clog2(BLOCK_SIZE);
    localparam int c_ENTRIES = 2 ** ADDR_W;
    localparam int c_MAX_LAT = (RD_LAT > WR_LAT) ? ((RD_LAT > ERR_LAT) ? RD_LAT : ERR_LAT)
                                                 : ((WR_LAT > ERR_LAT) ? WR_LAT : ERR_LAT);
    localparam int c_CNT_W   = $clog2(c_MAX_LAT) + 1;

    ssd_cmd_t              w_in;
    ssd_cmd_t              w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [$clog2(QDEPTH):0] w_count;
    logic                  w_pop;

    state_t                r_state;
    state_t                w_next;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_lat_m1;
    logic [7:0]            r_op;
    logic [63:0]           r_lba;
    logic [63:0]           r_data;
    logic                  r_err;

    logic [32:0]           w_span;
    logic                  w_err;
    logic                  w_complete;
    logic [ADDR_W-1:0]     w_idx;

    logic [63:0]           r_mem [c_ENTRIES];
    logic [c_ENTRIES-1:0]  r_vld;
    logic [63:0]           r_rsp_data;
    logic                  r_rsp_err;
    logic [63:0]           r_rsp_lba;

    assign w_in = '{opcode: bus.ssd_opcode, lba: bus.ssd_lba,
                    length: bus.ssd_length, data: bus.ssd_data};

    ssd_cmd_fifo #(
        .QDEPTH (QDEPTH),
        .T      (ssd_cmd_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.ssd_cmd_valid),
        .din   (w_in),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Block-crossing test is done in 33 bits so a huge length cannot wrap.
    assign w_span = 33'(w_head.lba[c_OFS_W-1:0]) + 33'(w_head.length);
    assign w_err  = (w_head.opcode > OP_WRITE)
                 || (w_head.length == '0)
                 || (w_span > 33'(BLOCK_SIZE))
                 || (|w_head.lba[63:c_OFS_W+ADDR_W]);

    assign w_lat_m1 = w_err                       ? c_CNT_W'(ERR_LAT - 1) :
                      (w_head.opcode == OP_READ)  ? c_CNT_W'(RD_LAT - 1)  :
                                                    c_CNT_W'(WR_LAT - 1);

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_BUSY;
                end
            end
            ST_BUSY: if (r_cnt == '0) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_lba   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_pop) begin
                r_op   <= w_head.opcode;
                r_lba  <= w_head.lba;
                r_data <= w_head.data;
                r_err  <= w_err;
                r_cnt  <= w_lat_m1;
            end else if (r_state == ST_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign w_complete = (r_state == ST_BUSY) && (r_cnt == '0);
    assign w_idx      = r_lba[c_OFS_W +: ADDR_W];

    // Store contents survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (!rst && w_complete && !r_err && r_op == OP_WRITE) r_mem[w_idx] <= r_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_rsp_lba  <= '0;
        end else if (w_complete) begin
            if (!r_err && r_op == OP_WRITE) r_vld[w_idx] <= 1'b1;
            r_rsp_data <= (!r_err && r_op == OP_READ && r_vld[w_idx]) ? r_mem[w_idx] : 64'd0;
            r_rsp_err  <= r_err;
            r_rsp_lba  <= r_lba;
        end
    end

    assign bus.ssd_cmd_ready  = !w_full;
    assign bus.ssd_data_ready = (r_state == ST_RESP);
    assign bus.rsp_data       = r_rsp_data;
    assign bus.rsp_err        = r_rsp_err;
    assign bus.rsp_lba        = r_rsp_lba;
    assign busy               = (r_state != ST_IDLE) || (w_count != '0);

`ifdef SSD_RESP_STATS_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;
    logic [31:0] r_stat_errors;
    logic [31:0] r_stat_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
            r_stat_errors <= '0;
            r_stat_busy   <= '0;
        end else begin
            if (r_state == ST_RESP) begin
                if (r_err) begin
                    if (r_stat_errors != '1) r_stat_errors <= r_stat_errors + 1'b1;
                end else if (r_op == OP_READ) begin
                    if (r_stat_reads != '1) r_stat_reads <= r_stat_reads + 1'b1;
                end else begin
                    if (r_stat_writes != '1) r_stat_writes <= r_stat_writes + 1'b1;
                end
            end
            if (busy && r_stat_busy != '1) r_stat_busy <= r_stat_busy + 1'b1;
        end
    end

    assign stat_reads       = r_stat_reads;
    assign stat_writes      = r_stat_writes;
    assign stat_errors      = r_stat_errors;
    assign stat_busy_cycles = r_stat_busy;
`endif

endmodule
`default_nettype wire
